// File: rtl/xt_hb_copy_master.sv
// xt_hb_copy_master: word-copy initiator for the XT high-speed bus.
// Reads LEN words starting at a source address and writes them to a
// destination address, one read/write pair per word. Bus ownership is
// negotiated with the HB arbiter through bus_req/bus_gnt, and a sticky
// done_irq is raised when the copy completes or is aborted.

module xt_hb_copy_master #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              hb_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] hb_raddr,
    output logic              hb_ren,
    input  logic [31:0]       hb_rdata,
    output logic [ADDR_W-1:0] hb_waddr,
    output logic [31:0]       hb_wdata,
    output logic              hb_wen,
    output logic              busy,
    output logic              done_irq,
    output logic [LEN_W-1:0]  words_left
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        RWAIT,
        WR,
        DONE
    } state_t;

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  words_left_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] raddr_hold_q;
    logic [ADDR_W-1:0] waddr_hold_q;
    logic [31:0]       wdata_hold_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              abort_pend_q;

    logic start_ok;
    logic abort_now;
    logic last_word;
    logic lat_last;
    logic enter_done;

    // Decode shared by the FSM and the datapath: start is only honoured in
    // IDLE, and an abort seen this cycle counts as pending immediately so a
    // pulse landing on a word boundary is not lost.
    assign start_ok   = (state_q == IDLE) && start;
    assign abort_now  = abort_pend_q || (busy_q && abort);
    assign last_word  = (words_left_q == LEN_W'(1));
    assign lat_last   = (lat_cnt_q == LAT_W'(RD_LAT - 1));
    assign enter_done = (state_d == DONE) && (state_q != DONE);

    assign busy       = busy_q;
    assign done_irq   = done_q;
    assign words_left = words_left_q;

    // State register; reset drops straight back to IDLE, which also kills
    // any read or write that was about to be issued.
    always_ff @(posedge hb_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; grant is only re-examined at word boundaries so a
    // read/write pair is never split by the arbiter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                if (abort_now) begin
                    state_d = DONE;
                end else if (bus_gnt) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = RWAIT;
            end
            RWAIT: begin
                if (lat_last) begin
                    state_d = WR;
                end
            end
            WR: begin
                if (last_word || abort_now) begin
                    state_d = DONE;
                end else if (bus_gnt) begin
                    state_d = RD;
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus-facing outputs; addresses and write data show the live value
    // during their strobe and the held copy otherwise.
    always_comb begin
        bus_req  = 1'b0;
        hb_ren   = 1'b0;
        hb_wen   = 1'b0;
        hb_raddr = raddr_hold_q;
        hb_waddr = waddr_hold_q;
        hb_wdata = wdata_hold_q;
        case (state_q)
            REQ: begin
                bus_req = 1'b1;
            end
            RD: begin
                bus_req  = 1'b1;
                hb_ren   = 1'b1;
                hb_raddr = src_q;
            end
            RWAIT: begin
                bus_req = 1'b1;
            end
            WR: begin
                bus_req  = 1'b1;
                hb_wen   = 1'b1;
                hb_waddr = dst_q;
                hb_wdata = rdata_q;
            end
            default: begin
                bus_req = 1'b0;
            end
        endcase
    end

    // Datapath: address/count bookkeeping, read-data capture, output hold
    // registers, abort latching and the busy/done flags.
    always_ff @(posedge hb_clk) begin
        if (rst) begin
            src_q        <= '0;
            dst_q        <= '0;
            words_left_q <= '0;
            rdata_q      <= '0;
            raddr_hold_q <= '0;
            waddr_hold_q <= '0;
            wdata_hold_q <= '0;
            lat_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            if (busy_q && abort) begin
                abort_pend_q <= 1'b1;
            end

            if (start_ok) begin
                src_q        <= src_addr & ALIGN_MASK;
                dst_q        <= dst_addr & ALIGN_MASK;
                words_left_q <= len;
                busy_q       <= 1'b1;
                abort_pend_q <= 1'b0;
                done_q       <= 1'b0;
            end

            if (enter_done) begin
                done_q <= 1'b1;
            end

            case (state_q)
                RD: begin
                    raddr_hold_q <= src_q;
                    lat_cnt_q    <= '0;
                end
                RWAIT: begin
                    lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    if (lat_last) begin
                        rdata_q <= hb_rdata;
                    end
                end
                WR: begin
                    waddr_hold_q <= dst_q;
                    wdata_hold_q <= rdata_q;
                    src_q        <= src_q + WORD_STEP;
                    dst_q        <= dst_q + WORD_STEP;
                    words_left_q <= words_left_q - LEN_W'(1);
                end
                DONE: begin
                    busy_q       <= 1'b0;
                    abort_pend_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xt_hb_copy_master.sv
// tb_xt_hb_copy_master: directed bench for the HB word-copy initiator.
// A registered slave model answers reads with an address-derived word;
// expected reads and writes are queued when a copy is started and popped
// by a monitor as the strobes appear on the bus.

module tb_xt_hb_copy_master;

    logic        hb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        bus_gnt = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        bus_req;
    logic [31:0] hb_raddr;
    logic        hb_ren;
    logic [31:0] hb_rdata = '0;
    logic [31:0] hb_waddr;
    logic [31:0] hb_wdata;
    logic        hb_wen;
    logic        busy;
    logic        done_irq;
    logic [15:0] words_left;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int ren_count = 0;
    int wen_count = 0;
    int wen_cyc[$];
    logic [31:0] exp_raddr[$];
    logic [31:0] exp_waddr[$];
    logic [31:0] exp_wdata[$];

    xt_hb_copy_master #(
        .ADDR_W(32),
        .LEN_W (16),
        .RD_LAT(1)
    ) dut (
        .hb_clk    (hb_clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .abort     (abort),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .hb_raddr  (hb_raddr),
        .hb_ren    (hb_ren),
        .hb_rdata  (hb_rdata),
        .hb_waddr  (hb_waddr),
        .hb_wdata  (hb_wdata),
        .hb_wen    (hb_wen),
        .busy      (busy),
        .done_irq  (done_irq),
        .words_left(words_left)
    );

    // Free-running bus clock and cycle counter.
    always #5 hb_clk = ~hb_clk;

    always @(posedge hb_clk) cyc <= cyc + 1;

    // Content the slave returns for a given address.
    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E} + 32'h0000_1001;
    endfunction

    // Slave model: rdata is registered on the ren edge (one cycle latency).
    always @(posedge hb_clk) begin
        if (hb_ren) hb_rdata <= slave_word(hb_raddr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Step to just after the falling edge, clear of the active edge.
    task automatic tick();
        @(negedge hb_clk);
        #1;
    endtask

    // Pulse start and queue the reads/writes the copy should produce.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] n, input int n_words);
        logic [31:0] sa;
        logic [31:0] da;
        tick();
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n_words; i++) begin
            exp_raddr.push_back(sa + 32'(4 * i));
            exp_waddr.push_back(da + 32'(4 * i));
            exp_wdata.push_back(slave_word(sa + 32'(4 * i)));
        end
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(output int done_cyc);
        bit seen;
        seen = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (done_irq === 1'b1) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        checkOutput("done_irq_timeout", 32'(seen), 32'd1);
    endtask

    task automatic waitRen();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (hb_ren === 1'b1) seen = 1'b1;
        end
        checkOutput("ren_timeout", 32'(seen), 32'd1);
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
        checkOutput({pfx, "_done_irq"}, 32'(done_irq), 32'd0);
        checkOutput({pfx, "_bus_req"}, 32'(bus_req), 32'd0);
        checkOutput({pfx, "_ren"}, 32'(hb_ren), 32'd0);
        checkOutput({pfx, "_wen"}, 32'(hb_wen), 32'd0);
        checkOutput({pfx, "_raddr"}, hb_raddr, 32'd0);
        checkOutput({pfx, "_waddr"}, hb_waddr, 32'd0);
        checkOutput({pfx, "_wdata"}, hb_wdata, 32'd0);
        checkOutput({pfx, "_words_left"}, 32'(words_left), 32'd0);
    endtask

    task automatic checkQueuesEmpty(input string pfx);
        checkOutput({pfx, "_reads_left"}, 32'(exp_raddr.size()), 32'd0);
        checkOutput({pfx, "_writes_left"}, 32'(exp_waddr.size()), 32'd0);
    endtask

    // Bus monitor: strobe exclusivity and scoreboard comparison.
    always @(negedge hb_clk) begin
        if (hb_ren || hb_wen) begin
            checkOutput("strobe_exclusive", 32'(hb_ren & hb_wen), 32'd0);
        end
        if (hb_ren) begin
            ren_count++;
            n_assert++;
            assert (exp_raddr.size() != 0)
            else begin
                n_fail++;
                $error("[TB] FAIL unexpected_ren: observed read at %h, expected no read", hb_raddr);
            end
            if (exp_raddr.size() != 0) checkOutput("raddr", hb_raddr, exp_raddr.pop_front());
        end
        if (hb_wen) begin
            wen_count++;
            wen_cyc.push_back(cyc);
            n_assert++;
            assert (exp_waddr.size() != 0)
            else begin
                n_fail++;
                $error("[TB] FAIL unexpected_wen: observed write at %h, expected no write", hb_waddr);
            end
            if (exp_waddr.size() != 0) begin
                checkOutput("waddr", hb_waddr, exp_waddr.pop_front());
                checkOutput("wdata", hb_wdata, exp_wdata.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ren0;
        int wen0;
        int done_cyc;
        int k;

        // Reset state.
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        bus_gnt = 1'b1;

        // Basic copy, grant held.
        $display("[TB] basic copy");
        ren0 = ren_count;
        wen0 = wen_count;
        wen_cyc.delete();
        applyStimulus(32'h100, 32'h200, 16'd3, 3);
        checkOutput("basic_busy", 32'(busy), 32'd1);
        waitDone(done_cyc);
        checkOutput("basic_ren_count", 32'(ren_count - ren0), 32'd3);
        checkOutput("basic_wen_count", 32'(wen_count - wen0), 32'd3);
        checkOutput("basic_words_left", 32'(words_left), 32'd0);
        checkOutput("basic_bus_req_done", 32'(bus_req), 32'd0);
        if (wen_cyc.size() == 3) begin
            checkOutput("basic_word_pitch1", 32'(wen_cyc[1] - wen_cyc[0]), 32'd3);
            checkOutput("basic_word_pitch2", 32'(wen_cyc[2] - wen_cyc[1]), 32'd3);
            checkOutput("basic_irq_after_wen", 32'(done_cyc - wen_cyc[2]), 32'd1);
        end else begin
            checkOutput("basic_wen_records", 32'(wen_cyc.size()), 32'd3);
        end
        checkQueuesEmpty("basic");
        tick();
        checkOutput("basic_busy_after", 32'(busy), 32'd0);
        checkOutput("basic_irq_sticky", 32'(done_irq), 32'd1);

        // Zero-length start.
        $display("[TB] len=0");
        ren0 = ren_count;
        wen0 = wen_count;
        applyStimulus(32'h100, 32'h200, 16'd0, 0);
        checkOutput("len0_done_irq", 32'(done_irq), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd1);
        checkOutput("len0_bus_req", 32'(bus_req), 32'd0);
        tick();
        checkOutput("len0_busy_drop", 32'(busy), 32'd0);
        checkOutput("len0_bus_req2", 32'(bus_req), 32'd0);
        checkOutput("len0_done_irq2", 32'(done_irq), 32'd1);
        checkOutput("len0_strobes", 32'((ren_count - ren0) + (wen_count - wen0)), 32'd0);

        // Grant withheld, then dropped during the first word's read wait.
        $display("[TB] grant withheld/dropped");
        bus_gnt = 1'b0;
        ren0 = ren_count;
        wen0 = wen_count;
        applyStimulus(32'h300, 32'h400, 16'd2, 2);
        checkOutput("gnt_irq_cleared", 32'(done_irq), 32'd0);
        checkOutput("gnt_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("gnt_wait_bus_req", 32'(bus_req), 32'd1);
        end
        checkOutput("gnt_wait_strobes", 32'((ren_count - ren0) + (wen_count - wen0)), 32'd0);
        bus_gnt = 1'b1;
        waitRen();
        bus_gnt = 1'b0;
        tick();
        tick();
        checkOutput("gnt_drop_wen", 32'(hb_wen), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("gnt_drop_ren_count", 32'(ren_count - ren0), 32'd1);
        checkOutput("gnt_drop_wen_count", 32'(wen_count - wen0), 32'd1);
        checkOutput("gnt_drop_bus_req", 32'(bus_req), 32'd1);
        checkOutput("gnt_drop_words_left", 32'(words_left), 32'd1);
        bus_gnt = 1'b1;
        waitDone(done_cyc);
        checkOutput("gnt_wen_count", 32'(wen_count - wen0), 32'd2);
        checkOutput("gnt_words_left", 32'(words_left), 32'd0);
        checkQueuesEmpty("gnt");

        // Abort during the third word's read.
        $display("[TB] abort");
        ren0 = ren_count;
        wen0 = wen_count;
        applyStimulus(32'h1000, 32'h2000, 16'd8, 3);
        k = 0;
        for (int i = 0; i < 100 && k < 3; i++) begin
            if (hb_ren === 1'b1) k++;
            if (k < 3) tick();
        end
        checkOutput("abort_third_ren", 32'(k), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        waitDone(done_cyc);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("abort_wen_count", 32'(wen_count - wen0), 32'd3);
        checkOutput("abort_ren_count", 32'(ren_count - ren0), 32'd3);
        checkOutput("abort_words_left", 32'(words_left), 32'd5);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkQueuesEmpty("abort");

        // Source address wrap and unaligned destination.
        $display("[TB] wrap");
        wen0 = wen_count;
        applyStimulus(32'hFFFF_FFFC, 32'h203, 16'd2, 2);
        waitDone(done_cyc);
        checkOutput("wrap_wen_count", 32'(wen_count - wen0), 32'd2);
        checkOutput("wrap_words_left", 32'(words_left), 32'd0);
        checkQueuesEmpty("wrap");

        // Reset while waiting for read data.
        $display("[TB] reset mid-transfer");
        ren0 = ren_count;
        wen0 = wen_count;
        applyStimulus(32'h500, 32'h600, 16'd4, 0);
        exp_raddr.push_back(32'h500);
        waitRen();
        tick();
        rst = 1'b1;
        tick();
        checkAllZero("midreset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("midreset_wen_count", 32'(wen_count - wen0), 32'd0);
        checkOutput("midreset_ren_count", 32'(ren_count - ren0), 32'd1);
        wen0 = wen_count;
        applyStimulus(32'h700, 32'h800, 16'd1, 1);
        waitDone(done_cyc);
        checkOutput("post_reset_wen_count", 32'(wen_count - wen0), 32'd1);
        checkOutput("post_reset_words_left", 32'(words_left), 32'd0);
        checkQueuesEmpty("post_reset");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/xt_hb_copy_master.md
Name: xt_hb_copy_master

Overview:
- Word-copy bus initiator on the XT high-speed bus. It moves LEN 32-bit words from a source region to a destination region by issuing read and write strobes into XT HB slaves (timer, RAM, peripherals).
- Initiator-side counterpart of the slave register protocol: drives raddr/ren, samples registered rdata, then drives waddr/wdata/wen.
- Gated by a simple request/grant handshake with the HB arbiter. Raises a completion interrupt.

Parameters:
- ADDR_W, 32, bus address width; addresses are byte addresses, word-aligned.
- LEN_W, 16, width of word-count register.
- RD_LAT, 1, cycles from ren to valid rdata (slave registers rdata on the ren edge).

Ports:
- hb_clk  in  1  bus clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- src_addr  in  ADDR_W  source start address; bits [1:0] ignored (forced 0).
- dst_addr  in  ADDR_W  destination start address; bits [1:0] ignored.
- len  in  LEN_W  number of words to copy.
- abort  in  1  stop after the current word completes.
- bus_req  out  1  request bus ownership.
- bus_gnt  in  1  arbiter grant; valid for the same cycle.
- hb_raddr  out  ADDR_W  read address.
- hb_ren  out  1  read strobe, one cycle per word.
- hb_rdata  in  32  read data, valid RD_LAT cycles after hb_ren.
- hb_waddr  out  ADDR_W  write address.
- hb_wdata  out  32  write data.
- hb_wen  out  1  write strobe, one cycle per word.
- busy  out  1  high from start acceptance to DONE exit.
- done_irq  out  1  sticky completion flag.
- words_left  out  LEN_W  remaining word count.

Behaviour:
- Reset values (rst sampled high on posedge):
  - state=IDLE.
  - All outputs 0, including busy, done_irq, bus_req, hb_ren, hb_wen, addresses, wdata and words_left.
  - Reset mid-transfer aborts immediately with no further strobes, including a pending write.
- States: IDLE, REQ, RD, RWAIT, WR, DONE.
- IDLE:
  - start with len!=0: latch {src,dst} with [1:0]=0 and words_left=len; busy=1; go to REQ.
  - start with len==0: go to DONE directly. No bus_req, no strobes.
  - start in any other state is ignored.
- REQ:
  - bus_req=1.
  - bus_gnt=1 and abort not pending: go to RD.
  - abort pending: go to DONE.
- RD:
  - Exactly one cycle: hb_ren=1, hb_raddr=src.
  - Go to RWAIT, waiting RD_LAT cycles.
- RWAIT:
  - Capture hb_rdata into a 32-bit holding register on the cycle it is valid (RD_LAT cycles after ren).
  - Then go to WR.
- WR:
  - One cycle: hb_wen=1, hb_waddr=dst, hb_wdata=captured word.
  - Same edge: src+=4, dst+=4 (modulo 2^ADDR_W, wrap silently), words_left-=1.
  - Next state:
    - words_left (old) ==1 or abort pending: DONE.
    - Else if bus_gnt still high: RD (back-to-back).
    - Else: REQ.
- bus_req stays high in REQ, RD, RWAIT and WR. It drops in DONE/IDLE.
- Grant loss is only honoured at word boundaries. A read/write pair is never split.
- Strobe exclusivity: hb_ren and hb_wen are never high in the same cycle. Each is a single-cycle pulse.
- Addresses and wdata hold their last values when strobes are low.
- abort:
  - Sampled every cycle while busy and stored as a pending flag.
  - Takes effect at the next word boundary (REQ, or end of WR).
  - words_left reflects the uncopied count.
- DONE:
  - Sets done_irq=1, busy=0, bus_req=0.
  - Goes to IDLE the next cycle.
- done_irq is cleared only by the next accepted start (same edge) or by rst.
- Throughput: with grant held, 2+RD_LAT cycles per word (3 for default).

Test Plan:
- Basic copy: src=0x100, dst=0x200, len=3, gnt tied 1, slave model RD_LAT=1.
  - Expect ren at 0x100/0x104/0x108 and wen at 0x200/0x204/0x208 with matching data.
  - Each word takes 3 cycles; done_irq rises exactly one cycle after the last wen; words_left=0.
- len=0 start:
  - Expect no bus_req, no ren/wen; done_irq=1 within 1 cycle; busy pulses 1 cycle.
- Grant withheld/dropped:
  - gnt=0 for 5 cycles after start: expect no strobes and bus_req held 1.
  - Drop gnt during word 1's RWAIT: word 1's wen still issues. Word 2's ren waits for gnt to return.
- Abort mid-transfer, len=8, abort pulse during word 3's RD:
  - Word 3 write completes, then DONE; exactly 3 wen total; words_left=5.
- Address wrap: src=0xFFFFFFFC, len=2.
  - Second read at 0x00000000. Unaligned dst=0x203 is treated as 0x200.
- Reset mid-write-wait: assert rst in RWAIT.
  - Next cycle all outputs 0, no wen ever issued. A subsequent start with len=1 copies correctly.
